systolic_data_setup: RTL and testbench

Input skew stage that sits directly upstream of the MACC array and feeds each row's `in` operand. It accepts one activation vector per cycle over a valid/ready handshake and delays element r by r cycles, producing the diagonal wavefront the systolic array needs. After the final vector it drains the skew pipeline and then signals completion. It shares the array's `enable` so that skew and array stall together.

---
 rtl/vTPU_pkg.sv | 15 +
 rtl/skew_delay_line.sv | 39 +++
 rtl/systolic_data_setup.sv | 111 +++++++++++
 tb/tb_systolic_data_setup.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vTPU_pkg.sv
// Shared vTPU types: the sign-extended byte element and the input-skew FSM states.
package vTPU_pkg;

    localparam int unsigned BYTE_WIDTH          = 8;
    localparam int unsigned EXTENDED_BYTE_WIDTH = BYTE_WIDTH + 1;

    typedef logic [EXTENDED_BYTE_WIDTH-1:0] EXTENDED_BYTE_TYPE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } SETUP_STATE_TYPE;

endpackage

// File: rtl/skew_delay_line.sv
// Per-row delay line of DEPTH stages carrying element data and a valid flag.
module skew_delay_line
    import vTPU_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_enable,
    input  logic              i_valid,
    input  EXTENDED_BYTE_TYPE i_data,
    output EXTENDED_BYTE_TYPE o_data,
    output logic              o_valid
);

    EXTENDED_BYTE_TYPE r_data  [DEPTH];
    logic              r_valid [DEPTH];

    // Bubbles enter as zero data with valid low so the wavefront keeps its alignment.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_data[i]  <= '0;
                r_valid[i] <= 1'b0;
            end
        end else if (i_enable) begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_valid ? i_data : '0;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_valid[DEPTH-1] ? r_data[DEPTH-1] : '0;

endmodule

// File: rtl/systolic_data_setup.sv
// Input skew stage for the MACC array: row r sees each accepted vector r enabled cycles later.
module systolic_data_setup
    import vTPU_pkg::*;
#(
    parameter int unsigned MATRIX_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    input  EXTENDED_BYTE_TYPE [MATRIX_WIDTH-1:0] in_data,
    output logic                                 in_ready,
    output EXTENDED_BYTE_TYPE [MATRIX_WIDTH-1:0] out_data,
    output logic              [MATRIX_WIDTH-1:0] out_valid,
    output logic                                 busy,
    output logic                                 done
);

    localparam int unsigned CNT_W    = $clog2(MATRIX_WIDTH) + 1;
    localparam int unsigned LAST_CNT = (MATRIX_WIDTH > 1) ? MATRIX_WIDTH - 2 : 0;

    SETUP_STATE_TYPE  r_state;
    SETUP_STATE_TYPE  w_state_next;
    logic [CNT_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0] w_drain_cnt_next;
    logic             r_done;
    logic             w_done_set;
    logic             w_accept;

    // State register; everything holds while the array is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
        end else if (enable) begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_cnt_next;
        end
    end

    // Next state: drain lasts MATRIX_WIDTH-1 enabled edges after the last accept.
    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        w_done_set       = 1'b0;
        unique case (r_state)
            IDLE, STREAM: begin
                if (w_accept) begin
                    w_drain_cnt_next = '0;
                    if (in_last) begin
                        if (MATRIX_WIDTH == 1) begin
                            w_state_next = IDLE;
                            w_done_set   = 1'b1;
                        end else begin
                            w_state_next = DRAIN;
                        end
                    end else begin
                        w_state_next = STREAM;
                    end
                end
            end
            DRAIN: begin
                if (r_drain_cnt == CNT_W'(LAST_CNT)) begin
                    w_state_next     = IDLE;
                    w_drain_cnt_next = '0;
                    w_done_set       = 1'b1;
                end else begin
                    w_drain_cnt_next = r_drain_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next     = IDLE;
                w_drain_cnt_next = '0;
            end
        endcase
    end

    // Outputs decoded from state; ready never looks at in_valid.
    always_comb begin
        in_ready = enable && (r_state != DRAIN);
        busy     = (r_state != IDLE);
        w_accept = in_valid && in_ready;
    end

    // done rises with the last element on the final row and holds through a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
        end else if (enable) begin
            r_done <= w_done_set;
        end
    end

    assign done = r_done;

    for (genvar r = 0; r < int'(MATRIX_WIDTH); r++) begin : g_row
        skew_delay_line #(
            .DEPTH(r + 1)
        ) u_skew (
            .clk     (clk),
            .reset   (reset),
            .i_enable(enable),
            .i_valid (w_accept),
            .i_data  (in_data[r]),
            .o_data  (out_data[r]),
            .o_valid (out_valid[r])
        );
    end

endmodule

// File: tb/tb_systolic_data_setup.sv
// Scoreboard bench for systolic_data_setup with MATRIX_WIDTH=4.
module tb_systolic_data_setup;
    import vTPU_pkg::*;

    localparam int unsigned N = 4;

    typedef struct {
        int         due;
        logic [8:0] data;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic                  in_valid;
    logic                  in_last;
    EXTENDED_BYTE_TYPE [N-1:0] in_data;
    logic                  in_ready;
    EXTENDED_BYTE_TYPE [N-1:0] out_data;
    logic [N-1:0]          out_valid;
    logic                  busy;
    logic                  done;

    exp_t row_q [N][$];
    int   done_q[$];
    int   n_edge    = 0;
    int   n_cmp     = 0;
    int   n_err     = 0;
    bit   in_drain  = 1'b0;
    bit   busy_m    = 1'b0;
    int   drain_end = 0;

    systolic_data_setup #(.MATRIX_WIDTH(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0][8:0] vec(input int a, input int b, input int c, input int e);
        return {9'(e), 9'(c), 9'(b), 9'(a)};
    endfunction

    task automatic check_outputs();
        for (int r = 0; r < int'(N); r++) begin
            bit         ev;
            logic [8:0] ed;
            while (row_q[r].size() > 0 && row_q[r][0].due < n_edge) void'(row_q[r].pop_front());
            ev = (row_q[r].size() > 0 && row_q[r][0].due == n_edge);
            ed = ev ? row_q[r][0].data : 9'd0;
            chk($sformatf("row%0d_valid", r), 32'(out_valid[r]), 32'(ev));
            chk($sformatf("row%0d_data", r), 32'(out_data[r]), 32'(ed));
        end
        while (done_q.size() > 0 && done_q[0] < n_edge) void'(done_q.pop_front());
        chk("done", 32'(done), 32'(done_q.size() > 0 && done_q[0] == n_edge));
        chk("busy", 32'(busy), 32'(busy_m));
    endtask

    task automatic step(input bit v, input bit last, input logic [N-1:0][8:0] d,
                        input bit en, input bit rst);
        bit exp_ready;
        bit acc;
        in_valid = v;
        in_last  = last;
        in_data  = d;
        enable   = en;
        reset    = rst;
        #1;
        exp_ready = en && !in_drain;
        if (!rst) chk("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = v && exp_ready && !rst;
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < int'(N); r++) row_q[r].delete();
            done_q.delete();
            in_drain = 1'b0;
            busy_m   = 1'b0;
        end else if (en) begin
            n_edge++;
            if (acc) begin
                for (int r = 0; r < int'(N); r++) row_q[r].push_back('{due: n_edge + r, data: d[r]});
                busy_m = 1'b1;
                if (last) begin
                    in_drain  = 1'b1;
                    drain_end = n_edge + int'(N) - 1;
                    done_q.push_back(drain_end);
                end
            end
            if (in_drain && n_edge >= drain_end) begin
                in_drain = 1'b0;
                busy_m   = 1'b0;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        enable   = 1'b1;
        reset    = 1'b1;
        @(negedge clk);

        // Reset for two cycles with enable high
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Single vector with last
        step(1'b1, 1'b1, vec(1, 2, 3, 4), 1'b1, 1'b0);
        idle(5);

        // Back-to-back vectors with negative elements
        step(1'b1, 1'b0, vec(-1, -2, -3, -4), 1'b1, 1'b0);
        step(1'b1, 1'b0, vec(5, 6, 7, 8), 1'b1, 1'b0);
        step(1'b1, 1'b1, vec(-256, 100, -100, -256), 1'b1, 1'b0);
        idle(5);

        // New stream accepted in the cycle done is high
        step(1'b1, 1'b1, vec(9, 10, 11, 12), 1'b1, 1'b0);
        idle(3);
        step(1'b1, 1'b1, vec(13, -14, 15, 255), 1'b1, 1'b0);
        idle(5);

        // One-cycle bubble between two vectors
        step(1'b1, 1'b0, vec(21, 22, 23, 24), 1'b1, 1'b0);
        step(1'b0, 1'b0, vec(99, 99, 99, 99), 1'b1, 1'b0);
        step(1'b1, 1'b1, vec(31, 32, 33, 34), 1'b1, 1'b0);
        idle(6);

        // Stall mid-drain, with a vector offered during drain that must be ignored
        step(1'b1, 1'b1, vec(41, 42, 43, 44), 1'b1, 1'b0);
        step(1'b1, 1'b0, vec(77, 78, 79, 80), 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        idle(5);

        // Reset in the middle of drain: no done afterwards
        step(1'b1, 1'b1, vec(51, 52, 53, 54), 1'b1, 1'b0);
        idle(1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
